// File: rtl/rv_decode_pkg.sv
// Shared RV32I(+M) decode definitions: opcodes, ALU/branch operation codes
// and the field widths that make up the decoded bundle.
package rv_decode_pkg;

  localparam int INST_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_SIZE_W = 3;
  // reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal
  localparam int CTRL_FLAG_W = 7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18,
    BR_EQ      = 5'd19,
    BR_NE      = 5'd20,
    BR_LT      = 5'd21,
    BR_GE      = 5'd22,
    BR_LTU     = 5'd23,
    BR_GEU     = 5'd24
  } alu_op_e;

  // Total width of the packed decoded bundle for a given datapath/op width.
  function automatic int bundle_width(input int xlen, input int aluop_w);
    return 2 * xlen + 3 * REG_ADDR_W + aluop_w + MEM_SIZE_W + CTRL_FLAG_W;
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready buffer (output register + skid register) with flush.
// in_ready is registered and is simply "skid register is empty next cycle".
module decode_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             drain;
  logic             out_free;

  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;
  assign out_free = ~out_valid | drain;

  // Buffer state: flush wins, the skid entry always refills the output first to keep order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
      in_ready <= 1'b1;
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage_hs.sv
// RV32I(+M) decode stage: combinational decode of one instruction into a
// bundle that is buffered by a 2-entry valid/ready skid buffer.
module decode_stage_hs
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1,
  parameter int ALUOP_W  = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        instruction_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               reg_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [2:0]         mem_size_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic               alu_src_imm_o,
  output logic               illegal_o
);

  localparam int BW = bundle_width(XLEN, ALUOP_W);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        shl_ok;
  logic        shr_ok;

  assign opcode   = instruction_i[6:0];
  assign funct3   = instruction_i[14:12];
  assign funct7   = instruction_i[31:25];
  assign rd_field = instruction_i[11:7];

  assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                  instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign imm_u = {instruction_i[31:12], 12'b0};
  assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                  instruction_i[20], instruction_i[30:21], 1'b0};

  // RV64 shift immediates use a 6-bit shamt, so the funct field shrinks by one bit.
  assign shl_ok = (XLEN == 64) ? (instruction_i[31:26] == 6'b000000)
                               : (funct7 == 7'b0000000);
  assign shr_ok = (XLEN == 64) ? (instruction_i[31:26] == 6'b000000 ||
                                  instruction_i[31:26] == 6'b010000)
                               : (funct7 == 7'b0000000 || funct7 == 7'b0100000);

  alu_op_e            alu_code;
  logic signed [31:0] imm32;
  logic               has_rd;
  logic               dec_illegal;
  logic               dec_mem_read;
  logic               dec_mem_write;
  logic               dec_branch;
  logic               dec_jump;
  logic               dec_alu_src_imm;
  logic [2:0]         dec_mem_size;

  // Opcode/funct decode; anything not recognised is flagged illegal but still flows on.
  always_comb begin
    alu_code        = ALU_ADD;
    imm32           = '0;
    has_rd          = 1'b0;
    dec_illegal     = 1'b0;
    dec_mem_read    = 1'b0;
    dec_mem_write   = 1'b0;
    dec_branch      = 1'b0;
    dec_jump        = 1'b0;
    dec_alu_src_imm = 1'b0;
    dec_mem_size    = 3'b000;
    case (opcode)
      OPC_LUI: begin
        has_rd = 1'b1; dec_alu_src_imm = 1'b1; imm32 = imm_u; alu_code = ALU_PASSB;
      end
      OPC_AUIPC: begin
        has_rd = 1'b1; dec_alu_src_imm = 1'b1; imm32 = imm_u;
      end
      OPC_JAL: begin
        has_rd = 1'b1; dec_jump = 1'b1; dec_alu_src_imm = 1'b1; imm32 = imm_j;
      end
      OPC_JALR: begin
        has_rd = 1'b1; dec_jump = 1'b1; dec_alu_src_imm = 1'b1; imm32 = imm_i;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1; imm32 = imm_b;
        case (funct3)
          3'b000:  alu_code = BR_EQ;
          3'b001:  alu_code = BR_NE;
          3'b100:  alu_code = BR_LT;
          3'b101:  alu_code = BR_GE;
          3'b110:  alu_code = BR_LTU;
          3'b111:  alu_code = BR_GEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        has_rd = 1'b1; dec_mem_read = 1'b1; dec_alu_src_imm = 1'b1; imm32 = imm_i;
        dec_mem_size = funct3;
        dec_illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_mem_write = 1'b1; dec_alu_src_imm = 1'b1; imm32 = imm_s;
        dec_mem_size = funct3;
        dec_illegal  = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        has_rd = 1'b1; dec_alu_src_imm = 1'b1; imm32 = imm_i;
        case (funct3)
          3'b000:  alu_code = ALU_ADD;
          3'b001:  begin alu_code = ALU_SLL; dec_illegal = ~shl_ok; end
          3'b010:  alu_code = ALU_SLT;
          3'b011:  alu_code = ALU_SLTU;
          3'b100:  alu_code = ALU_XOR;
          3'b101:  begin
            alu_code    = instruction_i[30] ? ALU_SRA : ALU_SRL;
            dec_illegal = ~shr_ok;
          end
          3'b110:  alu_code = ALU_OR;
          default: alu_code = ALU_AND;
        endcase
      end
      OPC_OP: begin
        has_rd = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  alu_code = ALU_ADD;
              3'b001:  alu_code = ALU_SLL;
              3'b010:  alu_code = ALU_SLT;
              3'b011:  alu_code = ALU_SLTU;
              3'b100:  alu_code = ALU_XOR;
              3'b101:  alu_code = ALU_SRL;
              3'b110:  alu_code = ALU_OR;
              default: alu_code = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  alu_code = ALU_SUB;
              3'b101:  alu_code = ALU_SRA;
              default: dec_illegal = 1'b1;
            endcase
          end
          7'b0000001: begin
            if (ENABLE_M != 0) begin
              case (funct3)
                3'b000:  alu_code = ALU_MUL;
                3'b001:  alu_code = ALU_MULH;
                3'b010:  alu_code = ALU_MULHSU;
                3'b011:  alu_code = ALU_MULHU;
                3'b100:  alu_code = ALU_DIV;
                3'b101:  alu_code = ALU_DIVU;
                3'b110:  alu_code = ALU_REM;
                default: alu_code = ALU_REMU;
              endcase
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic [4:0]         rd_dec;
  logic [XLEN-1:0]    imm_ext;
  logic [ALUOP_W-1:0] alu_op_dec;
  logic               reg_write_dec;
  logic [BW-1:0]      bundle_in;
  logic [BW-1:0]      bundle_out;

  assign rd_dec        = has_rd ? rd_field : 5'd0;
  assign imm_ext       = XLEN'(imm32);
  assign alu_op_dec    = ALUOP_W'(alu_code);
  assign reg_write_dec = has_rd & (rd_field != 5'd0) & ~dec_illegal;

  assign bundle_in = {pc_i, instruction_i[19:15], instruction_i[24:20], rd_dec, imm_ext,
                      alu_op_dec, reg_write_dec, dec_mem_read & ~dec_illegal,
                      dec_mem_write & ~dec_illegal, dec_mem_size,
                      dec_branch & ~dec_illegal, dec_jump & ~dec_illegal,
                      dec_alu_src_imm, dec_illegal};

  decode_skid_buf #(.WIDTH(BW)) u_buf (
    .clk       (clk_i),
    .rst       (reset_i),
    .flush     (flush_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (bundle_in),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (bundle_out)
  );

  assign {pc_o, rs1_o, rs2_o, rd_o, imm_o, alu_op_o, reg_write_o, mem_read_o, mem_write_o,
          mem_size_o, branch_o, jump_o, alu_src_imm_o, illegal_o} = bundle_out;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed self-checking bench for decode_stage_hs (one ENABLE_M=1 and one ENABLE_M=0 instance).
module tb_decode_stage_hs;
  import rv_decode_pkg::*;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [31:0]      instruction = '0;
  logic [XLEN-1:0]  pc = '0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;

  logic               in_ready, out_valid, reg_write, mem_read, mem_write;
  logic               branch, jump, alu_src_imm, illegal;
  logic [XLEN-1:0]    pc_out, imm;
  logic [4:0]         rs1, rs2, rd;
  logic [ALUOP_W-1:0] alu_op;
  logic [2:0]         mem_size;

  logic               nm_in_ready, nm_out_valid, nm_reg_write, nm_mem_read, nm_mem_write;
  logic               nm_branch, nm_jump, nm_alu_src_imm, nm_illegal;
  logic [XLEN-1:0]    nm_pc_out, nm_imm;
  logic [4:0]         nm_rs1, nm_rs2, nm_rd;
  logic [ALUOP_W-1:0] nm_alu_op;
  logic [2:0]         nm_mem_size;

  int assert_count = 0;
  int fail_count   = 0;

  decode_stage_hs #(.XLEN(XLEN), .ENABLE_M(1), .ALUOP_W(ALUOP_W)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instruction_i(instruction), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .pc_o(pc_out), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
    .imm_o(imm), .alu_op_o(alu_op), .reg_write_o(reg_write), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_size_o(mem_size), .branch_o(branch), .jump_o(jump),
    .alu_src_imm_o(alu_src_imm), .illegal_o(illegal)
  );

  decode_stage_hs #(.XLEN(XLEN), .ENABLE_M(0), .ALUOP_W(ALUOP_W)) dut_no_m (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(nm_in_ready),
    .instruction_i(instruction), .pc_i(pc), .flush_i(flush), .out_valid_o(nm_out_valid),
    .out_ready_i(out_ready), .pc_o(nm_pc_out), .rs1_o(nm_rs1), .rs2_o(nm_rs2), .rd_o(nm_rd),
    .imm_o(nm_imm), .alu_op_o(nm_alu_op), .reg_write_o(nm_reg_write), .mem_read_o(nm_mem_read),
    .mem_write_o(nm_mem_write), .mem_size_o(nm_mem_size), .branch_o(nm_branch), .jump_o(nm_jump),
    .alu_src_imm_o(nm_alu_src_imm), .illegal_o(nm_illegal)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] p,
                               input logic ordy, input logic fl);
    in_valid    = v;
    instruction = inst;
    pc          = p;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset rd", rd, 0);
    checkOutput("reset imm", imm, 0);
    checkOutput("reset pc", pc_out, 0);
    reset = 1'b0;

    // ADDI x1,x0,-1
    applyStimulus(1, 32'hFFF00093, 32'h100, 1, 0);
    checkOutput("addi out_valid", out_valid, 1);
    checkOutput("addi rd", rd, 1);
    checkOutput("addi rs1", rs1, 0);
    checkOutput("addi imm", imm, 32'hFFFF_FFFF);
    checkOutput("addi alu_op", alu_op, ALU_ADD);
    checkOutput("addi reg_write", reg_write, 1);
    checkOutput("addi alu_src_imm", alu_src_imm, 1);
    checkOutput("addi pc", pc_out, 32'h100);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("addi drained", out_valid, 0);

    // SW x2,8(x1)
    applyStimulus(1, 32'h0020A423, 32'h104, 1, 0);
    checkOutput("sw rs1", rs1, 1);
    checkOutput("sw rs2", rs2, 2);
    checkOutput("sw rd", rd, 0);
    checkOutput("sw imm", imm, 8);
    checkOutput("sw mem_write", mem_write, 1);
    checkOutput("sw mem_size", mem_size, 3'b010);
    checkOutput("sw reg_write", reg_write, 0);

    // MUL x3,x1,x2 on both instances
    applyStimulus(1, 32'h022081B3, 32'h108, 1, 0);
    checkOutput("mul alu_op", alu_op, ALU_MUL);
    checkOutput("mul illegal", illegal, 0);
    checkOutput("mul reg_write", reg_write, 1);
    checkOutput("mul noM illegal", nm_illegal, 1);
    checkOutput("mul noM reg_write", nm_reg_write, 0);

    // LUI x5,0x80000: sign bit of U immediate
    applyStimulus(1, 32'h800002B7, 32'h10C, 1, 0);
    checkOutput("lui imm", imm, 32'h8000_0000);
    checkOutput("lui alu_op", alu_op, ALU_PASSB);
    checkOutput("lui rd", rd, 5);

    // BNE x1,x2,-4
    applyStimulus(1, 32'hFE209EE3, 32'h110, 1, 0);
    checkOutput("bne imm", imm, 32'hFFFF_FFFC);
    checkOutput("bne alu_op", alu_op, BR_NE);
    checkOutput("bne branch", branch, 1);
    checkOutput("bne rd", rd, 0);

    // SRAI x1,x2,3 selected by bit 30
    applyStimulus(1, 32'h40315093, 32'h114, 1, 0);
    checkOutput("srai alu_op", alu_op, ALU_SRA);

    // JAL x1,8
    applyStimulus(1, 32'h008000EF, 32'h118, 1, 0);
    checkOutput("jal jump", jump, 1);
    checkOutput("jal imm", imm, 8);
    checkOutput("jal alu_op", alu_op, ALU_ADD);

    // Unknown opcode
    applyStimulus(1, 32'hFFFFFFFF, 32'h11C, 1, 0);
    checkOutput("bad illegal", illegal, 1);
    checkOutput("bad reg_write", reg_write, 0);
    checkOutput("bad out_valid", out_valid, 1);
    applyStimulus(0, 0, 0, 1, 0);

    // Back-pressure: three back-to-back inputs with out_ready low
    applyStimulus(1, 32'h00100093, 32'h200, 0, 0);
    checkOutput("bp A out_valid", out_valid, 1);
    checkOutput("bp A in_ready", in_ready, 1);
    applyStimulus(1, 32'h00200113, 32'h204, 0, 0);
    checkOutput("bp B in_ready", in_ready, 0);
    checkOutput("bp B pc hold", pc_out, 32'h200);
    applyStimulus(1, 32'h00300193, 32'h208, 0, 0);
    checkOutput("bp C in_ready", in_ready, 0);
    checkOutput("bp C pc hold", pc_out, 32'h200);
    checkOutput("bp C rd hold", rd, 1);
    applyStimulus(1, 32'h00300193, 32'h208, 1, 0);
    checkOutput("bp drain1 pc", pc_out, 32'h204);
    checkOutput("bp drain1 in_ready", in_ready, 1);
    applyStimulus(1, 32'h00300193, 32'h208, 1, 0);
    checkOutput("bp drain2 pc", pc_out, 32'h208);
    checkOutput("bp drain2 rd", rd, 3);
    checkOutput("bp drain2 out_valid", out_valid, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("bp empty", out_valid, 0);

    // Flush with both entries full and a new input offered
    applyStimulus(1, 32'h00100093, 32'h300, 0, 0);
    applyStimulus(1, 32'h00200113, 32'h304, 0, 0);
    checkOutput("fl full in_ready", in_ready, 0);
    applyStimulus(1, 32'h00400213, 32'h308, 0, 1);
    checkOutput("fl out_valid", out_valid, 0);
    checkOutput("fl in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("fl nothing emitted", out_valid, 0);
    end

    // Asynchronous reset mid-stall with both entries full
    applyStimulus(1, 32'h00100093, 32'h400, 0, 0);
    applyStimulus(1, 32'h00200113, 32'h404, 0, 0);
    in_valid = 1'b0;
    checkOutput("rst pre in_ready", in_ready, 0);
    #3 reset = 1'b1;
    #1;
    checkOutput("rst async out_valid", out_valid, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst release in_ready", in_ready, 1);
    applyStimulus(1, 32'h00500393, 32'h500, 1, 0);
    checkOutput("post rst out_valid", out_valid, 1);
    checkOutput("post rst rd", rd, 7);
    checkOutput("post rst imm", imm, 5);
    checkOutput("post rst pc", pc_out, 32'h500);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("post rst empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
